ram_port_arbiter: RTL

Parametrised successor to the single-mux RAM steering in the top-level coordinator. It arbitrates NUM_CH requesters (file loader, decompressor, CNN engine, external host) onto the one DMA/RAM port. Arbitration is round-robin with a per-channel enable mask and a priority-lock mode. Transactions carry full request/grant/done handshakes and a timeout watchdog. The block also owns the compressed-stream byte/bit cursor that the decompressor advances.

---
 rtl/ram_port_arbiter_pkg.sv | 10 +
 rtl/ram_port_arbiter_if.sv | 22 ++
 rtl/ram_port_arbiter_rr_picker.sv | 22 ++
 rtl/ram_port_arbiter.sv | 104 ++++++++++
 4 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// ram_arb_pkg: shared FSM encoding and width helper for the RAM port arbiter.
package ram_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} ArbState;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side and DMA-side bus of the RAM port arbiter.
interface ram_port_arbiter_if #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [NUM_CH-1:0] ch_en, ch_req, ch_we, ch_gnt, ch_done, ch_err;
  logic lock_en;
  logic [NUM_CH*ADDR_W-1:0] ch_addr;
  logic [NUM_CH*DATA_W-1:0] ch_wdata;
  logic [DATA_W-1:0] ch_rdata, ram_wdata, ram_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic ram_rd, ram_wr, ram_done_rd, ram_done_wr;
  modport slave (
    input ch_en, lock_en, ch_req, ch_we, ch_addr, ch_wdata, ram_done_rd, ram_done_wr, ram_rdata,
    output ch_gnt, ch_done, ch_err, ch_rdata, ram_addr, ram_wdata, ram_rd, ram_wr
  );
  modport master (
    output ch_en, lock_en, ch_req, ch_we, ch_addr, ch_wdata, ram_done_rd, ram_done_wr, ram_rdata,
    input ch_gnt, ch_done, ch_err, ch_rdata, ram_addr, ram_wdata, ram_rd, ram_wr
  );
endinterface

// File: rtl/ram_port_arbiter_rr_picker.sv
// rr_picker: next winner from eligible channels, round-robin from rrPtr or lowest index when locked.
module rr_picker import ram_arb_pkg::*; #(
  parameter int NUM_CH = 4,
  localparam int PW = clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] elig,
  input  logic [PW-1:0]     rrPtr,
  input  logic              lockEn,
  output logic [PW-1:0]     idx,
  output logic              valid
);
  function automatic int slot(input int k, input logic [PW-1:0] ptr, input logic lk);
    return lk ? k : (int'(ptr) + k) % NUM_CH;
  endfunction
  // Scan from the farthest offset down so the nearest eligible slot is the one left in idx.
  always_comb begin
    idx = '0;
    for (int k = NUM_CH - 1; k >= 0; k--)
      if (elig[slot(k, rrPtr, lockEn)]) idx = PW'(slot(k, rrPtr, lockEn));
  end
  assign valid = |elig;
endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: arbitrates NUM_CH requesters onto one DMA/RAM port and owns the stream cursor.
module ram_port_arbiter import ram_arb_pkg::*; #(
  parameter int NUM_CH   = 4,
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int CURSOR_W = 32,
  parameter int TIMEOUT  = 255
) (
  input  logic                clk,
  input  logic                RST,
  ram_port_arbiter_if.slave   bus,
  input  logic                cur_init,
  input  logic [ADDR_W-1:0]   cur_base,
  input  logic                cur_upd,
  input  logic [CURSOR_W-1:0] cur_new_byte,
  input  logic [2:0]          cur_new_bit,
  output logic [CURSOR_W-1:0] byte_idx,
  output logic [2:0]          bit_idx,
  output logic                busy
);
  localparam int PW = clog2(NUM_CH);
  localparam int TW = clog2(TIMEOUT);
  ArbState state, nextState;
  logic [PW-1:0] rrPtr, winIdx, pickIdx;
  logic pickValid, weLat, errFlag, doneHit, timeUp;
  logic [TW-1:0] timer;
  logic [ADDR_W-1:0] addrLat;
  logic [DATA_W-1:0] wdataLat, rdataLat;
  logic [NUM_CH-1:0] winHot;

  rr_picker #(.NUM_CH(NUM_CH)) picker (
    .elig(bus.ch_req & bus.ch_en), .rrPtr(rrPtr), .lockEn(bus.lock_en), .idx(pickIdx), .valid(pickValid)
  );

  assign doneHit = weLat ? bus.ram_done_wr : bus.ram_done_rd;
  assign timeUp  = timer == TW'(TIMEOUT - 1);

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:  nextState = pickValid ? ISSUE : IDLE;
      ISSUE: nextState = WAIT;
      WAIT:  nextState = (doneHit || timeUp) ? RESP : WAIT;
      RESP:  nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      rrPtr    <= '0;
      winIdx   <= '0;
      weLat    <= 1'b0;
      addrLat  <= '0;
      wdataLat <= '0;
      rdataLat <= '0;
      timer    <= '0;
      errFlag  <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && pickValid) begin
        winIdx   <= pickIdx;
        weLat    <= bus.ch_we[pickIdx];
        addrLat  <= bus.ch_addr[pickIdx*ADDR_W +: ADDR_W];
        wdataLat <= bus.ch_wdata[pickIdx*DATA_W +: DATA_W];
      end
      if (state == ISSUE) begin
        timer   <= '0;
        errFlag <= 1'b0;
      end
      // A done arriving on the timeout cycle still counts as success.
      if (state == WAIT) begin
        timer <= timer + 1'b1;
        if (doneHit && !weLat) rdataLat <= bus.ram_rdata;
        if (!doneHit && timeUp) errFlag <= 1'b1;
      end
      if (state == RESP) begin
        rrPtr   <= winIdx == PW'(NUM_CH - 1) ? '0 : winIdx + 1'b1;
        errFlag <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      byte_idx <= '0;
      bit_idx  <= '0;
    end else begin
      byte_idx <= cur_init ? CURSOR_W'(cur_base) : cur_upd ? cur_new_byte : byte_idx;
      bit_idx  <= cur_init ? 3'd0 : cur_upd ? cur_new_bit : bit_idx;
    end
  end

  assign winHot        = NUM_CH'(1) << winIdx;
  assign bus.ch_gnt    = state != IDLE ? winHot : '0;
  assign bus.ch_done   = state == RESP ? winHot : '0;
  assign bus.ch_err    = (state == RESP && errFlag) ? winHot : '0;
  assign bus.ch_rdata  = rdataLat;
  assign bus.ram_addr  = addrLat;
  assign bus.ram_wdata = wdataLat;
  assign bus.ram_rd    = state == WAIT && !weLat;
  assign bus.ram_wr    = state == WAIT && weLat;
  assign busy          = state != IDLE;
endmodule
